vedic8_seq_mul: RTL and testbench
=================================

# vedic8_seq_mul

Sequential 8x8 unsigned multiplier controller. It time-shares a single 4x4 Vedic partial-product core across the four nibble cross-products of an 8-bit operand pair, accumulates them into a 16-bit product, and exposes valid/ready handshakes on both sides. It sits between the operand source (ALU issue logic) and the result consumer. It replaces four parallel 4x4 cores with one core plus a small FSM.

## Interface
- No parameters; widths are fixed at 8x8 to 16.
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands a/b present
- in_ready  output  1  block can accept operands
- a  input  8  multiplicand, unsigned
- b  input  8  multiplier, unsigned
- out_valid  output  1  product p valid
- out_ready  input  1  consumer accepts p
- p  output  16  product a*b, unsigned

## Operation
- FSM states: IDLE, PP_LL, PP_LH, PP_HL, PP_HH, DONE.
- IDLE: in_ready=1. When in_valid&in_ready, the block:
  - latches a into a_q and b into b_q;
  - clears acc to 0;
  - moves to PP_LL.
- Per PP state, the core multiplies one nibble pair; the block adds the 8-bit product, zero-extended and shifted, into acc:
  - PP_LL: a_q[3:0]*b_q[3:0], shift 0, next PP_LH.
  - PP_LH: a_q[3:0]*b_q[7:4], shift 4, next PP_HL.
  - PP_HL: a_q[7:4]*b_q[3:0], shift 4, next PP_HH.
  - PP_HH: a_q[7:4]*b_q[7:4], shift 8, next DONE.
- Arithmetic: acc is 16-bit and carry-out is discarded. Partial sums are monotonic and bounded by 255*255=65025, so no overflow occurs.
- DONE: out_valid=1 and p=acc.
  - p holds stable while out_valid&!out_ready.
  - On out_valid&out_ready the block returns to IDLE.
- in_ready=0 in every state except IDLE, so there is no accept in the same cycle as output.
- in_valid and operand changes are ignored outside IDLE.
- Reset values: state=IDLE, out_valid=0, p=0, acc=0, a_q=0, b_q=0. in_ready is forced to 0 during any cycle with rst=1.
- Reset mid-operation (any state): the in-flight product is discarded and no out_valid pulse is produced. The block is in IDLE with in_ready=1 in the first cycle after rst deasserts.

## Timing
- Cycle 0 is the accept cycle (in_valid&in_ready=1).
- Cycles 1–4: PP_LL, PP_LH, PP_HL, PP_HH.
- Cycle 5: out_valid=1. Latency is 5 cycles.
- Earliest next accept is the cycle after the output handshake. Peak throughput is one product per 6 cycles with out_ready tied high.
- out_valid is a registered output. in_ready is decoded from the state register (gated by rst).
- The core is combinational; its inputs come from a_q/b_q nibble muxes selected by state.

## Configuration
- Macro: VEDIC8_ZERO_SKIP_EN.
- Defined: on accept with a==0 or b==0, the FSM goes directly IDLE->DONE with acc=0. out_valid=1 in cycle 1, giving latency 1.
- Undefined: every operand pair takes the full 4 PP states, including zero operands. Latency is always 5.
- All other behaviour is identical with and without the macro.

## Structure
- Shared package vedic_pkg:
  - state enum typedef (IDLE, PP_LL, PP_LH, PP_HL, PP_HH, DONE);
  - width localparams OP_W=8, NIB_W=4, PROD_W=16, PP_W=8;
  - shift constants SH_LL=0, SH_MID=4, SH_HH=8.
- Sub-module mul4_core: combinational 4x4 unsigned Vedic multiplier producing an 8-bit product, instantiated once.
- The controller contains the FSM, operand registers, nibble select muxes, the shifter and the 16-bit accumulator.

## Test plan
- Basic product: a=0x0F, b=0x0F, out_ready=1 -> out_valid in cycle 5, p=0x00E1 (225); in_ready returns to 1 in cycle 6.
- Max operands: a=0xFF, b=0xFF -> p=0xFE01 (65025), no wrap. Also a=0xA5, b=0x3C -> p=0x26AC (9900).
- Backpressure: a=0x12, b=0x34 with out_ready=0 for 7 cycles after out_valid -> p=0x03A8 held stable and out_valid held high. in_valid asserted with new operands during this period is not accepted (in_ready=0). The output handshake completes when out_ready rises.
- Reset mid-operation: assert rst in PP_HL -> the next cycle has out_valid=0, p=0 and in_ready=0. After release, in_ready=1. A new a=3, b=5 yields p=15 with no stale result.
- Zero operand: a=0x00, b=0x7F:
  - with VEDIC8_ZERO_SKIP_EN, p=0 in cycle 1;
  - without it, p=0 in cycle 5.
- Back-to-back streaming: 100 random operand pairs with random out_ready -> every p equals a*b in order, with no drops or duplicates.

Source files
------------

// File: rtl/vedic8_seq_mul_pkg.sv
// vedic_pkg: shared widths, shift amounts and FSM states for the 8x8 sequential Vedic multiplier.
package vedic_pkg;
    localparam int OP_W   = 8;
    localparam int NIB_W  = 4;
    localparam int PROD_W = 16;
    localparam int PP_W   = 8;
    localparam int SH_LL  = 0;
    localparam int SH_MID = 4;
    localparam int SH_HH  = 8;
    typedef enum logic [2:0] {IDLE, PP_LL, PP_LH, PP_HL, PP_HH, DONE} state_t;
endpackage

// File: rtl/vedic8_seq_mul_if.sv
// vedic8_seq_mul_if: operand/product valid-ready bus; slave is the multiplier, master the source/consumer side.
interface vedic8_seq_mul_if;
    import vedic_pkg::*;
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   a;
    logic [OP_W-1:0]   b;
    logic              out_valid;
    logic              out_ready;
    logic [PROD_W-1:0] p;
    modport slave  (input in_valid, a, b, out_ready, output in_ready, out_valid, p);
    modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, p);
endinterface

// File: rtl/vedic8_seq_mul_mul4_core.sv
// mul4_core: combinational 4x4 unsigned Vedic multiplier built from four 2x2 Urdhva-Tiryagbhyam blocks.
module mul4_core
    import vedic_pkg::*;
(
    input  logic [NIB_W-1:0] x,
    input  logic [NIB_W-1:0] y,
    output logic [PP_W-1:0]  z
);
    function automatic logic [3:0] vm2(input logic [1:0] u, input logic [1:0] v);
        logic t, w, c, h;
        t = u[1] & v[0];
        w = u[0] & v[1];
        c = t & w;
        h = u[1] & v[1];
        return {h & c, h ^ c, t ^ w, u[0] & v[0]};
    endfunction
    logic [3:0] ll, lh, hl, hh;
    logic [4:0] mid;
    always_comb begin
        ll  = vm2(x[1:0], y[1:0]);
        lh  = vm2(x[1:0], y[3:2]);
        hl  = vm2(x[3:2], y[1:0]);
        hh  = vm2(x[3:2], y[3:2]);
        mid = 5'(lh) + 5'(hl);
        z   = {hh, ll} + (8'(mid) << 2);
    end
endmodule

// File: rtl/vedic8_seq_mul.sv
// vedic8_seq_mul: 8x8 multiplier sharing one 4x4 Vedic core over four nibble cross-products.
// Optional VEDIC8_ZERO_SKIP_EN sends zero-operand pairs straight to DONE.
module vedic8_seq_mul
    import vedic_pkg::*;
(
    input logic clk,
    input logic rst,
    vedic8_seq_mul_if.slave bus
);
    state_t            state, state_n;
    logic [OP_W-1:0]   a_q, b_q;
    logic [PROD_W-1:0] acc, add;
    logic [NIB_W-1:0]  na, nb;
    logic [PP_W-1:0]   pp;
    logic [3:0]        sh;
    logic              out_valid_q, accept, skip, is_pp;
`ifdef VEDIC8_ZERO_SKIP_EN
    assign skip = (bus.a == '0) || (bus.b == '0);
`else
    assign skip = 1'b0;
`endif
    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.p         = acc;
    assign accept        = bus.in_valid && bus.in_ready;
    mul4_core u_core (.x(na), .y(nb), .z(pp));
    always_comb begin
        is_pp = (state != IDLE) && (state != DONE);
        na    = (state == PP_HL || state == PP_HH) ? a_q[OP_W-1:NIB_W] : a_q[NIB_W-1:0];
        nb    = (state == PP_LH || state == PP_HH) ? b_q[OP_W-1:NIB_W] : b_q[NIB_W-1:0];
        sh    = state == PP_LL ? 4'(SH_LL) : state == PP_HH ? 4'(SH_HH) : 4'(SH_MID);
        add   = PROD_W'(pp) << sh;
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = skip ? DONE : PP_LL;
            PP_LL:   state_n = PP_LH;
            PP_LH:   state_n = PP_HL;
            PP_HL:   state_n = PP_HH;
            PP_HH:   state_n = DONE;
            DONE:    if (bus.out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            acc         <= '0;
            a_q         <= '0;
            b_q         <= '0;
        end else begin
            state       <= state_n;
            out_valid_q <= state_n == DONE;
            if (accept) begin
                a_q <= bus.a;
                b_q <= bus.b;
                acc <= '0;
            end else if (is_pp) begin
                acc <= acc + add;
            end
        end
    end
endmodule

// File: tb/tb_vedic8_seq_mul.sv
// tb_vedic8_seq_mul: directed checks of latency, products, backpressure, reset and a random stream.
module tb_vedic8_seq_mul;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    vedic8_seq_mul_if bus();
    vedic8_seq_mul dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic run(input string tag, input logic [7:0] x, input logic [7:0] y,
                       input logic [15:0] prod, input int lat_exp);
        int lat;
        check({tag, "_in_ready"}, 32'(bus.in_ready), 1);
        bus.a = x;
        bus.b = y;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(lat_exp));
        check({tag, "_p"}, 32'(bus.p), 32'(prod));
        tick();
        check({tag, "_valid_drop"}, 32'(bus.out_valid), 0);
        check({tag, "_ready_back"}, 32'(bus.in_ready), 1);
    endtask
    initial begin
        int zlat;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 32'(bus.in_ready), 0);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_p", 32'(bus.p), 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 1);
        run("basic", 8'h0F, 8'h0F, 16'h00E1, 5);
        run("max", 8'hFF, 8'hFF, 16'hFE01, 5);
        run("a5x3c", 8'hA5, 8'h3C, 16'h26AC, 5);
        run("hi_lo", 8'h80, 8'h02, 16'h0100, 5);
        run("one", 8'h01, 8'hFF, 16'h00FF, 5);
`ifdef VEDIC8_ZERO_SKIP_EN
        zlat = 1;
`else
        zlat = 5;
`endif
        run("zero", 8'h00, 8'h7F, 16'h0000, zlat);
        bus.a = 8'h12;
        bus.b = 8'h34;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        bus.a = 8'h77;
        bus.b = 8'h99;
        for (int i = 0; i < 4; i++) tick();
        check("bp_valid_rise", 32'(bus.out_valid), 1);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("bp_valid_hold", 32'(bus.out_valid), 1);
            check("bp_p_hold", 32'(bus.p), 32'h03A8);
            check("bp_in_ready", 32'(bus.in_ready), 0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("bp_release_valid", 32'(bus.out_valid), 0);
        check("bp_release_ready", 32'(bus.in_ready), 1);
        bus.a = 8'h55;
        bus.b = 8'h66;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("midrst_valid", 32'(bus.out_valid), 0);
        check("midrst_p", 32'(bus.p), 0);
        check("midrst_in_ready", 32'(bus.in_ready), 0);
        rst = 1'b0;
        #1;
        check("midrst_release", 32'(bus.in_ready), 1);
        run("after_rst", 8'd3, 8'd5, 16'd15, 5);
        for (int n = 0; n < 100; n++) begin
            logic [7:0] x, y;
            int guard;
            bit done;
            x = 8'($urandom);
            y = 8'($urandom);
            guard = 0;
            while (!bus.in_ready && guard < 20) begin
                bus.out_ready = 1'b1;
                tick();
                guard++;
            end
            check("stream_in_ready", 32'(bus.in_ready), 1);
            bus.a = x;
            bus.b = y;
            bus.in_valid = 1'b1;
            bus.out_ready = 1'($urandom_range(0, 1));
            tick();
            bus.in_valid = 1'b0;
            done = 1'b0;
            guard = 0;
            while (!done && guard < 60) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                if (bus.out_valid && bus.out_ready) begin
                    check("stream_p", 32'(bus.p), 32'(16'(x) * 16'(y)));
                    done = 1'b1;
                end
                tick();
                guard++;
            end
            check("stream_handshake", 32'(done), 1);
            check("stream_no_dup", 32'(bus.out_valid), 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
